// File: rtl/key_event_decoder.sv
// key_event_decoder: turns raw active-low push-button pins into debounced levels,
// press/release/auto-repeat pulses and a lowest-index-wins event code.
module key_event_decoder #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000,
    parameter int CNT_W           = 25,
    localparam int CODE_W         = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_repeat,
    output logic                ev_valid,
    output logic [CODE_W-1:0]   ev_code
);
    localparam logic [1:0]       ST_IDLE   = 2'd0;
    localparam logic [1:0]       ST_HOLD   = 2'd1;
    localparam logic [1:0]       ST_REPEAT = 2'd2;
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    logic [NUM_KEYS-1:0] sync1_r;
    logic [NUM_KEYS-1:0] sync2_r;
    logic [NUM_KEYS-1:0] evt_s;
    logic [CODE_W-1:0]   code_s;

    // Two-flop synchroniser; inverted so that 1 means pressed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= {NUM_KEYS{1'b0}};
            sync2_r <= {NUM_KEYS{1'b0}};
        end else begin
            sync1_r <= ~key_n;
            sync2_r <= sync1_r;
        end
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        logic [CNT_W-1:0] db_cnt_r;
        logic [CNT_W-1:0] hold_cnt_r;
        logic [CNT_W-1:0] hold_cnt_s;
        logic [1:0]       st_r;
        logic [1:0]       st_s;
        logic             level_r;
        logic             press_r;
        logic             release_r;
        logic             repeat_r;
        logic             repeat_s;
        logic             mismatch_s;
        logic             toggle_s;

        // A level change needs DEBOUNCE_CYCLES consecutive disagreeing samples.
        always_comb begin
            mismatch_s = sync2_r[i] ^ level_r;
            toggle_s   = mismatch_s && (db_cnt_r == DB_LAST);
        end

        // Debounce counter, level and the edge pulses that share its toggle edge.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                db_cnt_r  <= {CNT_W{1'b0}};
                level_r   <= 1'b0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
            end else begin
                if (toggle_s) begin
                    level_r  <= ~level_r;
                    db_cnt_r <= {CNT_W{1'b0}};
                end else if (mismatch_s) begin
                    db_cnt_r <= db_cnt_r + 1'b1;
                end else begin
                    db_cnt_r <= {CNT_W{1'b0}};
                end
                press_r   <= toggle_s & ~level_r;
                release_r <= toggle_s & level_r;
            end
        end

        // Hold/repeat next state; a release toggle wins over a due repeat.
        always_comb begin
            st_s       = st_r;
            hold_cnt_s = hold_cnt_r;
            repeat_s   = 1'b0;
            if (toggle_s) begin
                hold_cnt_s = {CNT_W{1'b0}};
                st_s       = level_r ? ST_IDLE : ST_HOLD;
            end else begin
                case (st_r)
                    ST_HOLD: begin
                        if (hold_cnt_r == HOLD_LAST) begin
                            repeat_s   = 1'b1;
                            hold_cnt_s = {CNT_W{1'b0}};
                            st_s       = ST_REPEAT;
                        end else begin
                            hold_cnt_s = hold_cnt_r + 1'b1;
                        end
                    end
                    ST_REPEAT: begin
                        if (hold_cnt_r == REP_LAST) begin
                            repeat_s   = 1'b1;
                            hold_cnt_s = {CNT_W{1'b0}};
                        end else begin
                            hold_cnt_s = hold_cnt_r + 1'b1;
                        end
                    end
                    default: begin
                        st_s       = ST_IDLE;
                        hold_cnt_s = {CNT_W{1'b0}};
                    end
                endcase
            end
        end

        // Hold/repeat state registers.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                st_r       <= ST_IDLE;
                hold_cnt_r <= {CNT_W{1'b0}};
                repeat_r   <= 1'b0;
            end else begin
                st_r       <= st_s;
                hold_cnt_r <= hold_cnt_s;
                repeat_r   <= repeat_s;
            end
        end

        assign key_level[i]   = level_r;
        assign key_press[i]   = press_r;
        assign key_release[i] = release_r;
        assign key_repeat[i]  = repeat_r;
    end

    // Lowest key index with a press or repeat owns the event code.
    always_comb begin
        evt_s  = key_press | key_repeat;
        code_s = {CODE_W{1'b0}};
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (evt_s[k]) begin
                code_s = CODE_W'(k);
            end else begin
                code_s = code_s;
            end
        end
    end

    // Registered event output, one cycle behind the per-key pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ev_valid <= 1'b0;
            ev_code  <= {CODE_W{1'b0}};
        end else begin
            ev_valid <= |evt_s;
            ev_code  <= code_s;
        end
    end
endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: a vector table and directed corner sequences, then
// random bouncing stimulus, all compared each cycle against a window-based model.
module tb_key_event_decoder;
    localparam int NK   = 4;
    localparam int DEB  = 4;
    localparam int HOLD = 10;
    localparam int REP  = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [NK-1:0] key_n;
    logic [NK-1:0] key_level, key_press, key_release, key_repeat;
    logic          ev_valid;
    logic [1:0]    ev_code;

    int checks = 0;
    int errs   = 0;

    // model state: input history per edge since reset, level and press edge per key
    logic [NK-1:0] inh [0:63];
    int            m_e;
    int            m_pe [NK];
    logic [NK-1:0] m_lvl, m_press, m_release, m_repeat;
    logic          m_ev_valid;
    logic [1:0]    m_ev_code;

    typedef struct {
        logic [3:0] kn;
        logic [3:0] lvl;
        logic [3:0] prs;
        logic [3:0] rel;
        logic       ev;
        logic [1:0] code;
    } vec_t;
    vec_t tbl[$];

    key_event_decoder #(
        .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD),
        .REPEAT_CYCLES(REP), .CNT_W(8)
    ) dut (
        .clk(clk), .reset(reset), .key_n(key_n),
        .key_level(key_level), .key_press(key_press), .key_release(key_release),
        .key_repeat(key_repeat), .ev_valid(ev_valid), .ev_code(ev_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic samp(input int idx, input int k);
        if (idx < 1) return 1'b0;
        return inh[idx % 64][k];
    endfunction

    task automatic model_reset();
        m_e = 0;
        m_lvl = '0; m_press = '0; m_release = '0; m_repeat = '0;
        m_ev_valid = 1'b0; m_ev_code = 2'd0;
        for (int k = 0; k < NK; k++) m_pe[k] = 0;
    endtask

    // Rules: level flips when the last DEB synchronised samples (2 edges old) all
    // disagree with it; repeats fall HOLD + n*REP edges after the press edge.
    task automatic model_edge();
        logic [NK-1:0] evt;
        logic          tog;
        int            d;
        m_e++;
        inh[m_e % 64] = ~key_n;
        evt = m_press | m_repeat;
        m_ev_valid = |evt;
        m_ev_code = 2'd0;
        for (int k = NK - 1; k >= 0; k--) if (evt[k]) m_ev_code = 2'(k);
        for (int k = 0; k < NK; k++) begin
            tog = 1'b1;
            for (int j = 0; j < DEB; j++) if (samp(m_e - 2 - j, k) == m_lvl[k]) tog = 1'b0;
            m_press[k]   = tog & ~m_lvl[k];
            m_release[k] = tog & m_lvl[k];
            m_repeat[k]  = 1'b0;
            if (!tog && m_lvl[k]) begin
                d = m_e - m_pe[k];
                if (d >= HOLD && (d - HOLD) % REP == 0) m_repeat[k] = 1'b1;
            end
            if (tog) begin
                m_lvl[k] = ~m_lvl[k];
                if (m_lvl[k]) m_pe[k] = m_e;
            end
        end
    endtask

    // one clock: drive at negedge, model on posedge, compare 1 time unit later
    task automatic tick(input logic [3:0] kn);
        key_n = kn;
        @(posedge clk);
        model_edge();
        #1;
        chk("level",   32'(key_level),   32'(m_lvl));
        chk("press",   32'(key_press),   32'(m_press));
        chk("release", 32'(key_release), 32'(m_release));
        chk("repeat",  32'(key_repeat),  32'(m_repeat));
        chk("ev_valid", 32'(ev_valid),   32'(m_ev_valid));
        if (m_ev_valid) chk("ev_code", 32'(ev_code), 32'(m_ev_code));
        @(negedge clk);
    endtask

    task automatic add_rows(input int n, input logic [3:0] kn, input logic [3:0] lvl,
                            input logic [3:0] prs, input logic [3:0] rel,
                            input logic ev, input logic [1:0] code);
        vec_t v;
        v.kn = kn; v.lvl = lvl; v.prs = prs; v.rel = rel; v.ev = ev; v.code = code;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_level"},   32'(key_level),   32'd0);
        chk({tag, "_press"},   32'(key_press),   32'd0);
        chk({tag, "_release"}, 32'(key_release), 32'd0);
        chk({tag, "_repeat"},  32'(key_repeat),  32'd0);
        chk({tag, "_ev_valid"}, 32'(ev_valid),   32'd0);
        chk({tag, "_ev_code"}, 32'(ev_code),     32'd0);
    endtask

    initial begin
        logic [63:0] obs, expm;
        logic [3:0]  kn_r;
        int          mode [NK];
        int          cnt, cnt2, pidx;

        // key 1 press/release then key 0 press/release, one row per clock
        add_rows(5, 4'b1101, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
        add_rows(1, 4'b1101, 4'b0010, 4'b0010, 4'b0000, 1'b0, 2'd0);
        add_rows(1, 4'b1101, 4'b0010, 4'b0000, 4'b0000, 1'b1, 2'd1);
        add_rows(5, 4'b1111, 4'b0010, 4'b0000, 4'b0000, 1'b0, 2'd0);
        add_rows(1, 4'b1111, 4'b0000, 4'b0000, 4'b0010, 1'b0, 2'd0);
        add_rows(1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
        add_rows(5, 4'b1110, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
        add_rows(1, 4'b1110, 4'b0001, 4'b0001, 4'b0000, 1'b0, 2'd0);
        add_rows(1, 4'b1110, 4'b0001, 4'b0000, 4'b0000, 1'b1, 2'd0);
        add_rows(1, 4'b1110, 4'b0001, 4'b0000, 4'b0000, 1'b0, 2'd0);
        add_rows(5, 4'b1111, 4'b0001, 4'b0000, 4'b0000, 1'b0, 2'd0);
        add_rows(1, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 1'b0, 2'd0);
        add_rows(1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);

        reset = 1'b0;
        key_n = 4'b1111;
        model_reset();
        @(negedge clk);
        chk_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) tick(4'b1111);

        foreach (tbl[i]) begin
            tick(tbl[i].kn);
            chk("tbl_level",   32'(key_level),   32'(tbl[i].lvl));
            chk("tbl_press",   32'(key_press),   32'(tbl[i].prs));
            chk("tbl_release", 32'(key_release), 32'(tbl[i].rel));
            chk("tbl_repeat",  32'(key_repeat),  32'd0);
            chk("tbl_ev_valid", 32'(ev_valid),   32'(tbl[i].ev));
            if (tbl[i].ev) chk("tbl_ev_code", 32'(ev_code), 32'(tbl[i].code));
        end

        // bounce on key 0, then settle; release lands on the would-be first repeat
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            tick(((c / 2) % 2) == 1 ? 4'b1111 : 4'b1110);
            if (key_press[0] || key_release[0]) cnt++;
        end
        chk("bounce_no_pulse", 32'(cnt), 32'd0);
        cnt = 0; pidx = -1; cnt2 = 0;
        for (int c = 0; c < 10; c++) begin
            tick(4'b1110);
            if (key_press[0]) begin cnt++; pidx = c; end
            if (key_repeat[0]) cnt2++;
        end
        chk("settle_press_count", 32'(cnt), 32'd1);
        chk("settle_press_cycle", 32'(pidx), 32'd5);
        for (int r = 0; r < 15; r++) begin
            tick(4'b1111);
            if (key_repeat[0]) cnt2++;
            if (r == 5) chk("release_at_hold_edge", 32'(key_release[0]), 32'd1);
        end
        chk("no_repeat_on_release_edge", 32'(cnt2), 32'd0);

        // hold key 2: repeats at press+10, +13, ... until the release toggle
        obs = '0; expm = '0; cnt = 0;
        for (int o = 10; o <= 34; o += 3) expm[o + 5] = 1'b1;
        for (int idx = 0; idx <= 50; idx++) begin
            tick(idx <= 35 ? 4'b1011 : 4'b1111);
            if (key_repeat[2]) obs[idx] = 1'b1;
            if (key_release[2]) cnt++;
            if (idx == 5)  chk("hold_press", 32'(key_press[2]), 32'd1);
            if (idx == 41) chk("hold_release", 32'(key_release[2]), 32'd1);
        end
        chk("repeat_mask_lo", obs[31:0], expm[31:0]);
        chk("repeat_mask_hi", obs[63:32], expm[63:32]);
        chk("release_count", 32'(cnt), 32'd1);

        // keys 3 and 1 settle together
        cnt = 0;
        for (int idx = 0; idx <= 20; idx++) begin
            tick(idx <= 8 ? 4'b0101 : 4'b1111);
            if (idx == 5) chk("dual_press_vec", 32'(key_press), 32'ha);
            if (idx == 6) chk("dual_ev_code", 32'(ev_code), 32'd1);
            if (ev_valid) cnt++;
        end
        chk("dual_ev_count", 32'(cnt), 32'd1);

        // reset mid-hold with key 2 still down
        for (int idx = 0; idx <= 10; idx++) tick(4'b1011);
        chk("pre_reset_level", 32'(key_level), 32'h4);
        #2 reset = 1'b0;
        #1 chk_all_zero("midhold_reset");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        cnt = 0; pidx = -1;
        for (int idx = 0; idx < 12; idx++) begin
            tick(4'b1011);
            if (key_press[2]) begin cnt++; pidx = idx; end
        end
        chk("fresh_press_count", 32'(cnt), 32'd1);
        chk("fresh_press_cycle", 32'(pidx), 32'd5);
        for (int idx = 0; idx < 20; idx++) tick(4'b1111);

        // random segments: each key stable-pressed, stable-released or bouncing
        kn_r = 4'b1111;
        for (int seg = 0; seg < 40; seg++) begin
            for (int k = 0; k < NK; k++) begin
                mode[k] = int'($urandom_range(0, 2));
                if (mode[k] != 2) kn_r[k] = 1'($urandom_range(0, 1));
            end
            for (int t = 0; t < 40; t++) begin
                for (int k = 0; k < NK; k++)
                    if (mode[k] == 2 && $urandom_range(0, 2) == 0) kn_r[k] = ~kn_r[k];
                tick(kn_r);
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
